bitcoin_nonce_scheduler: RTL and testbench

Sequences a nonce sweep across `NUM_CORES` parallel double-SHA256 compression cores. It hands each idle core the next nonce and collects each finished core's first output word (H0). It writes that word to `output_addr + nonce` through the shared memory write port, and raises `done` once all `NUM_NONCES` results are written. It sits between the top-level start/done handshake and the hash cores, and owns the memory write port during a sweep.

---
 rtl/bitcoin_nonce_scheduler_pkg.sv | 13 +
 rtl/bitcoin_nonce_scheduler_if.sv | 26 ++
 rtl/bitcoin_nonce_scheduler_lowest_set_idx.sv | 20 ++
 rtl/bitcoin_nonce_scheduler.sv | 126 ++++++++++++
 tb/tb_bitcoin_nonce_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitcoin_nonce_scheduler_pkg.sv
// Shared types and defaults for the nonce sweep and the hash top level.
package bitcoin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_NONCES = 16;
  localparam int DEF_NUM_CORES  = 4;

endpackage

// File: rtl/bitcoin_nonce_scheduler_if.sv
// Scheduler-side bus: shared memory write port plus per-core launch/collect lanes.
interface bitcoin_nonce_scheduler_if import bitcoin_pkg::*; #(
  parameter int NUM_CORES = DEF_NUM_CORES
);
  logic                       mem_clk;
  logic                       mem_we;
  logic [15:0]                mem_addr;
  logic [31:0]                mem_write_data;
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES-1:0][31:0] core_nonce;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0][31:0] core_h0;
  logic [NUM_CORES-1:0]       core_ack;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    output core_start, core_nonce, core_ack,
    input  core_done, core_h0
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    input  core_start, core_nonce, core_ack,
    output core_done, core_h0
  );
endinterface

// File: rtl/bitcoin_nonce_scheduler_lowest_set_idx.sv
// Priority encoder: valid flag plus index of the lowest set request bit.
module lowest_set_idx #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/bitcoin_nonce_scheduler.sv
// Nonce sweep scheduler: one dispatch and one collect per cycle across NUM_CORES cores.
module bitcoin_nonce_scheduler import bitcoin_pkg::*; #(
  parameter int NUM_NONCES = DEF_NUM_NONCES,
  parameter int NUM_CORES  = DEF_NUM_CORES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] output_addr,
  output logic        done,
  bitcoin_nonce_scheduler_if.master bus
);

  localparam int CW = $clog2(NUM_NONCES + 1);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t               state_q, state_n;
  logic [NUM_CORES-1:0]       busy_q, core_start_q, core_ack_q;
  logic [NUM_CORES-1:0][31:0] core_nonce_q;
  logic [CW-1:0]              next_nonce_q, written_q;
  logic                       mem_we_q, done_q;
  logic [15:0]                mem_addr_q;
  logic [31:0]                mem_data_q;

  logic                       coll_vld, disp_vld, can_disp, last_write;
  logic [IW-1:0]              coll_idx, disp_idx;
  logic [NUM_CORES-1:0]       coll_oh;

  lowest_set_idx #(.W(NUM_CORES)) u_coll (
    .req (busy_q & bus.core_done),
    .vld (coll_vld),
    .idx (coll_idx)
  );

  // A core being collected this edge is still busy, so keep it out of dispatch.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_coll_oh
    assign coll_oh[g] = coll_vld && (coll_idx == IW'(g));
  end

  lowest_set_idx #(.W(NUM_CORES)) u_disp (
    .req (~busy_q & ~coll_oh),
    .vld (disp_vld),
    .idx (disp_idx)
  );

  assign can_disp   = disp_vld && (next_nonce_q < CW'(NUM_NONCES));
  assign last_write = coll_vld && (written_q == CW'(NUM_NONCES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state: leave RUN on the edge that collects the final result.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_write) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: counters, busy bits, launch/ack pulses and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      core_start_q <= '0;
      core_ack_q   <= '0;
      core_nonce_q <= '0;
      next_nonce_q <= '0;
      written_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      core_start_q <= '0;
      core_ack_q   <= '0;
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (start) begin
            busy_q       <= '0;
            next_nonce_q <= '0;
            written_q    <= '0;
            done_q       <= 1'b0;
          end
        end
        RUN: begin
          mem_we_q <= coll_vld;
          if (coll_vld) begin
            mem_addr_q           <= output_addr + core_nonce_q[coll_idx][15:0];
            mem_data_q           <= bus.core_h0[coll_idx];
            core_ack_q[coll_idx] <= 1'b1;
            busy_q[coll_idx]     <= 1'b0;
            written_q            <= written_q + 1'b1;
          end
          if (can_disp) begin
            core_start_q[disp_idx] <= 1'b1;
            core_nonce_q[disp_idx] <= 32'(next_nonce_q);
            busy_q[disp_idx]       <= 1'b1;
            next_nonce_q           <= next_nonce_q + 1'b1;
          end
        end
        FINISH: begin
          mem_we_q <= 1'b0;
          done_q   <= 1'b1;
        end
        default: mem_we_q <= 1'b0;
      endcase
    end
  end

  assign done               = done_q;
  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_data_q;
  assign bus.core_start     = core_start_q;
  assign bus.core_nonce     = core_nonce_q;
  assign bus.core_ack       = core_ack_q;

endmodule

// File: tb/tb_bitcoin_nonce_scheduler.sv
// Directed bench for the nonce scheduler with behavioural hash-core models.
module tb_bitcoin_nonce_scheduler;
  import bitcoin_pkg::*;

  localparam int NC = 4;
  localparam int NN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] output_addr;
  logic        done;

  bitcoin_nonce_scheduler_if #(.NUM_CORES(NC)) bus ();

  bitcoin_nonce_scheduler #(.NUM_NONCES(NN), .NUM_CORES(NC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .output_addr (output_addr),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core models and write monitor share one negedge process so the write log
  // sees each core's nonce before the model reacts to the ack.
  int          lat [NC];
  int          cnt [NC];
  logic [31:0] cur_nonce [NC];
  logic        active [NC];

  logic [15:0]   w_addr[$], w_exp[$];
  logic [31:0]   w_data[$];
  logic [NC-1:0] w_ack[$], w_snap[$];
  int            w_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      bus.core_done = '0;
      bus.core_h0   = '0;
      for (int k = 0; k < NC; k++) begin
        cnt[k] = 0; active[k] = 1'b0; cur_nonce[k] = '0;
      end
    end else begin
      if (bus.mem_we) begin
        int ai;
        ai = 0;
        for (int k = NC - 1; k >= 0; k--) if (bus.core_ack[k]) ai = k;
        w_addr.push_back(bus.mem_addr);
        w_data.push_back(bus.mem_write_data);
        w_ack.push_back(bus.core_ack);
        w_snap.push_back(bus.core_done);
        w_cyc.push_back(cyc);
        w_exp.push_back(output_addr + cur_nonce[ai][15:0]);
      end
      for (int k = 0; k < NC; k++) begin
        if (bus.core_ack[k]) begin
          bus.core_done[k] = 1'b0;
          active[k] = 1'b0;
        end
        if (bus.core_start[k]) begin
          cur_nonce[k] = bus.core_nonce[k];
          cnt[k] = lat[k];
          active[k] = 1'b1;
        end else if (active[k] && !bus.core_done[k]) begin
          if (cnt[k] <= 1) begin
            bus.core_done[k] = 1'b1;
            bus.core_h0[k]   = 32'hA000_0000 + cur_nonce[k];
          end else begin
            cnt[k] = cnt[k] - 1;
          end
        end
      end
    end
  end

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic clear_log();
    w_addr.delete(); w_exp.delete(); w_data.delete();
    w_ack.delete(); w_snap.delete(); w_cyc.delete();
  endtask

  // Pulse start for one edge; returns at the negedge just after that edge.
  task automatic begin_sweep(input logic [15:0] base);
    @(negedge clk);
    clear_log();
    output_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dcyc);
    ok = 1'b0; dcyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; dcyc = cyc; break; end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (w_addr.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  // Summarises the write log: nonces seen, duplicates, and writes whose
  // address, ack or payload disagree with the core that produced them.
  task automatic scan_writes(input logic [15:0] base, output logic [NN-1:0] seen,
                             output int dups, output int bad);
    seen = '0; dups = 0; bad = 0;
    foreach (w_data[i]) begin
      logic [31:0] n;
      n = w_data[i] - 32'hA000_0000;
      if (n >= 32'(NN)) bad++;
      else begin
        if (seen[n[3:0]]) dups++;
        seen[n[3:0]] = 1'b1;
      end
      if (w_addr[i] !== 16'(base + n[15:0])) bad++;
      if (w_addr[i] !== w_exp[i]) bad++;
      if (!$onehot(w_ack[i])) bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; output_addr = '0;
    set_lat(70, 70, 70, 70);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %0b want 0", done); end
    compared++;
    if (bus.mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); end
    compared++;
    if (bus.mem_addr !== 16'h0 || bus.mem_write_data !== 32'h0) begin
      mismatched++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_write_data);
    end
    compared++;
    if (bus.core_start !== '0 || bus.core_ack !== '0) begin
      mismatched++; $display("FAIL reset_pulses: got %b/%b want 0/0", bus.core_start, bus.core_ack);
    end
    compared++;
    if (bus.core_nonce !== '0) begin mismatched++; $display("FAIL reset_nonce: got %h want 0", bus.core_nonce); end
  endtask

  task automatic test_nominal();
    logic [NN-1:0] seen; int dups, bad, dcyc; bit ok;
    set_lat(70, 70, 70, 70);
    begin_sweep(16'h0100);
    compared++;
    if (bus.core_start !== 4'b0000 || done !== 1'b0) begin
      mismatched++; $display("FAIL start_lat_e: got start=%b done=%b want 0000/0", bus.core_start, done);
    end
    @(negedge clk);
    compared++;
    if (bus.core_start !== 4'b0001 || bus.core_nonce[0] !== 32'd0) begin
      mismatched++; $display("FAIL start_lat_core0: got %b nonce %0d want 0001 nonce 0", bus.core_start, bus.core_nonce[0]);
    end
    @(negedge clk);
    compared++;
    if (bus.core_start !== 4'b0010 || bus.core_nonce[1] !== 32'd1) begin
      mismatched++; $display("FAIL fill_core1: got %b nonce %0d want 0010 nonce 1", bus.core_start, bus.core_nonce[1]);
    end
    wait_done(2000, ok, dcyc);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL nominal_timeout: done never rose"); end
    compared++;
    if (w_addr.size() !== NN) begin mismatched++; $display("FAIL nominal_count: got %0d want %0d", w_addr.size(), NN); end
    for (int i = 0; i < NN && i < w_addr.size(); i++) begin
      compared++;
      if (w_addr[i] !== 16'h0100 + 16'(i) || w_data[i] !== 32'hA000_0000 + 32'(i)) begin
        mismatched++;
        $display("FAIL nominal_write%0d: got %h/%h want %h/%h", i, w_addr[i], w_data[i], 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i));
      end
    end
    scan_writes(16'h0100, seen, dups, bad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL nominal_scan: got %0d bad writes want 0", bad); end
    if (w_cyc.size() > 0) begin
      compared++;
      if (dcyc !== w_cyc[w_cyc.size()-1] + 1) begin
        mismatched++; $display("FAIL done_latency: got cycle %0d want %0d", dcyc, w_cyc[w_cyc.size()-1] + 1);
      end
    end
    repeat (5) @(negedge clk);
    compared++;
    if (done !== 1'b1 || bus.mem_we !== 1'b0) begin
      mismatched++; $display("FAIL done_hold: got done=%b we=%b want 1/0", done, bus.mem_we);
    end
  endtask

  task automatic test_out_of_order();
    logic [NN-1:0] seen; int dups, bad, dcyc; bit ok;
    set_lat(90, 40, 70, 20);
    begin_sweep(16'h0200);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL ooo_done_clear: got %b want 0", done); end
    wait_done(3000, ok, dcyc);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL ooo_timeout: done never rose"); end
    compared++;
    if (w_data.size() == 0 || w_data[0] !== 32'hA000_0003) begin
      mismatched++; $display("FAIL ooo_first: got %h want a0000003", (w_data.size() > 0) ? w_data[0] : 32'h0);
    end
    scan_writes(16'h0200, seen, dups, bad);
    compared++;
    if (seen !== {NN{1'b1}} || dups !== 0 || w_data.size() !== NN) begin
      mismatched++; $display("FAIL ooo_coverage: got seen=%h dups=%0d n=%0d want ffff/0/16", seen, dups, w_data.size());
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL ooo_addr: got %0d bad writes want 0", bad); end
  endtask

  task automatic test_simultaneous();
    logic [NN-1:0] seen; int dups, bad, dcyc; bit ok;
    logic [NC-1:0] mask;
    set_lat(70, 69, 68, 67);
    begin_sweep(16'h0300);
    wait_done(2000, ok, dcyc);
    compared++;
    if (!ok || w_data.size() < NC) begin mismatched++; $display("FAIL simul_timeout: done=%b writes=%0d", ok, w_data.size()); end
    else begin
      for (int i = 0; i < NC; i++) begin
        mask = 4'hF << i;
        compared++;
        if (w_cyc[i] !== w_cyc[0] + i || w_ack[i] !== NC'(1 << i) || w_data[i] !== 32'hA000_0000 + 32'(i)) begin
          mismatched++;
          $display("FAIL simul_order%0d: got cyc+%0d ack=%b data=%h want +%0d %b %h", i, w_cyc[i] - w_cyc[0], w_ack[i], w_data[i], i, NC'(1 << i), 32'hA000_0000 + 32'(i));
        end
        compared++;
        if ((w_snap[i] & mask) !== mask) begin
          mismatched++; $display("FAIL simul_hold%0d: got core_done=%b want %b set", i, w_snap[i], mask);
        end
      end
    end
    scan_writes(16'h0300, seen, dups, bad);
    compared++;
    if (seen !== {NN{1'b1}} || dups !== 0 || bad !== 0) begin
      mismatched++; $display("FAIL simul_scan: got seen=%h dups=%0d bad=%0d want ffff/0/0", seen, dups, bad);
    end
  endtask

  task automatic test_addr_wrap();
    logic [NN-1:0] seen; int dups, bad, dcyc; bit ok;
    set_lat(30, 30, 30, 30);
    begin_sweep(16'hFFF8);
    wait_done(2000, ok, dcyc);
    compared++;
    if (!ok || w_addr.size() !== NN) begin mismatched++; $display("FAIL wrap_run: done=%b writes=%0d want 1/16", ok, w_addr.size()); end
    else begin
      compared++;
      if (w_addr[7] !== 16'hFFFF || w_addr[8] !== 16'h0000 || w_addr[15] !== 16'h0007) begin
        mismatched++; $display("FAIL wrap_addr: got %h/%h/%h want ffff/0000/0007", w_addr[7], w_addr[8], w_addr[15]);
      end
    end
    scan_writes(16'hFFF8, seen, dups, bad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL wrap_scan: got %0d bad writes want 0", bad); end
  endtask

  task automatic test_reset_and_start();
    logic [NN-1:0] seen; int dups, bad, dcyc, n_before; bit ok;
    set_lat(10, 10, 10, 10);
    begin_sweep(16'h0400);
    wait_writes(5, 500, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL rst_wait: fewer than 5 writes"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_before = w_addr.size();
    compared++;
    if (bus.mem_we !== 1'b0 || bus.core_start !== '0 || done !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid: got we=%b start=%b done=%b want 0/0/0", bus.mem_we, bus.core_start, done);
    end
    repeat (40) @(negedge clk);
    compared++;
    if (w_addr.size() !== n_before || done !== 1'b0) begin
      mismatched++; $display("FAIL rst_quiet: got %0d writes done=%b want %0d/0", w_addr.size(), done, n_before);
    end
    begin_sweep(16'h0400);
    @(negedge clk);
    compared++;
    if (bus.core_start !== 4'b0001 || bus.core_nonce[0] !== 32'd0) begin
      mismatched++; $display("FAIL resweep_nonce0: got %b nonce %0d want 0001 nonce 0", bus.core_start, bus.core_nonce[0]);
    end
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, ok, dcyc);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL resweep_timeout: done never rose"); end
    scan_writes(16'h0400, seen, dups, bad);
    compared++;
    if (w_addr.size() !== NN || seen !== {NN{1'b1}} || dups !== 0 || bad !== 0) begin
      mismatched++; $display("FAIL start_in_run: got n=%0d seen=%h dups=%0d bad=%0d want 16/ffff/0/0", w_addr.size(), seen, dups, bad);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_out_of_order();
    test_simultaneous();
    test_addr_wrap();
    test_reset_and_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
